// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard interface: instruction descriptor from decode, pipeline control back.
// Parameters must match those of the pipeline_hazard_ctrl instance that uses it.
interface pipeline_hazard_ctrl_if #(
  parameter int SEL_BITS = 4,
  parameter int DEPTH    = 3,
  parameter int CNT_W    = 16
);
  localparam int SW = $clog2(DEPTH + 1);

  logic                dec_valid;
  logic [SEL_BITS-1:0] dec_rs1;
  logic                dec_rs1_use;
  logic [SEL_BITS-1:0] dec_rs2;
  logic                dec_rs2_use;
  logic [SEL_BITS-1:0] dec_rd;
  logic                dec_wr_sc;
  logic                dec_wr_vec;
  logic                dec_pc_wr;
  logic                stall_fd;
  logic                bubble_ex;
  logic                flush_fd;
  logic [SW-1:0]       fwd_sel1;
  logic [SW-1:0]       fwd_sel2;
  logic [SW-1:0]       inflight_cnt;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output dec_valid, dec_rs1, dec_rs1_use, dec_rs2, dec_rs2_use,
           dec_rd, dec_wr_sc, dec_wr_vec, dec_pc_wr,
    input  stall_fd, bubble_ex, flush_fd, fwd_sel1, fwd_sel2,
           inflight_cnt, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs1_use, dec_rs2, dec_rs2_use,
           dec_rd, dec_wr_sc, dec_wr_vec, dec_pc_wr,
    output stall_fd, bubble_ex, flush_fd, fwd_sel1, fwd_sel2,
           inflight_cnt, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard RAW-hazard / forwarding controller beside decode; tracks in-flight
// destinations and PC writes over DEPTH post-decode stages and counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int SEL_BITS = 4,
  parameter int DEPTH    = 3,
  parameter int FWD_EN   = 1,
  parameter int FWD_FROM = 1,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int SW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                v;
    logic [SEL_BITS-1:0] rd;
    logic                wrSc;
    logic                wrVec;
    logic                pcWr;
  } sbEntry_t;

  sbEntry_t         sb [DEPTH];
  logic [CNT_W-1:0] stallCycles;
  logic [SW-1:0]    fwdSel1, fwdSel2, inflight;
  logic             found1, found2;
  logic             rawStall1, rawStall2;
  logic             pcBusy, flushFd, stallFd, issue;

  // Register kind is ignored: a scalar and a vector write to the same select both hit.
  function automatic logic hit(input sbEntry_t e, input logic [SEL_BITS-1:0] rs,
                               input logic srcUse);
    return srcUse & e.v & (e.wrSc | e.wrVec) & (e.rd == rs);
  endfunction

  always_comb begin
    found1    = 1'b0;
    found2    = 1'b0;
    rawStall1 = 1'b0;
    rawStall2 = 1'b0;
    fwdSel1   = '0;
    fwdSel2   = '0;
    pcBusy    = 1'b0;
    inflight  = '0;
    // Scan from sb[0] so the youngest producer wins, even if it cannot forward.
    for (int i = 0; i < DEPTH; i++) begin
      if (!found1 && hit(sb[i], hz.dec_rs1, hz.dec_rs1_use & hz.dec_valid)) begin
        found1 = 1'b1;
        if ((FWD_EN != 0) && (i >= FWD_FROM)) fwdSel1 = SW'(i + 1);
        else                                  rawStall1 = 1'b1;
      end
      if (!found2 && hit(sb[i], hz.dec_rs2, hz.dec_rs2_use & hz.dec_valid)) begin
        found2 = 1'b1;
        if ((FWD_EN != 0) && (i >= FWD_FROM)) fwdSel2 = SW'(i + 1);
        else                                  rawStall2 = 1'b1;
      end
      inflight = inflight + SW'(sb[i].v);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (sb[i].v && sb[i].pcWr) pcBusy = 1'b1;
    end
  end

  assign flushFd = sb[DEPTH-1].v & sb[DEPTH-1].pcWr;
  assign stallFd = hz.dec_valid & ~flushFd & (rawStall1 | rawStall2 | pcBusy);
  assign issue   = hz.dec_valid & ~stallFd & ~flushFd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
      stallCycles <= '0;
    end else begin
      sb[0] <= issue ? sbEntry_t'{1'b1, hz.dec_rd, hz.dec_wr_sc, hz.dec_wr_vec, hz.dec_pc_wr}
                     : sbEntry_t'('0);
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
      if (stallFd && (stallCycles != {CNT_W{1'b1}})) stallCycles <= stallCycles + 1'b1;
    end
  end

  assign hz.stall_fd     = stallFd;
  assign hz.bubble_ex    = stallFd | flushFd;
  assign hz.flush_fd     = flushFd;
  assign hz.fwd_sel1     = fwdSel1;
  assign hz.fwd_sel2     = fwdSel2;
  assign hz.inflight_cnt = inflight;
  assign hz.stall_cycles = stallCycles;
endmodule
